// File: rtl/cla_pkg.sv
// Shared constants and types for the four-bit carry-lookahead adder slice.
package cla_pkg;

   localparam int CLA_W = 4;

   typedef logic [CLA_W-1:0] cla_word_t;

endpackage : cla_pkg

// File: rtl/cla_four_bit_if.sv
// Operand/result bundle for one CLA slice.
// The master drives the operands. The slave (the adder) drives every result.
interface cla_four_bit_if;
   import cla_pkg::*;

   cla_word_t a;
   cla_word_t b;
   logic      cin;
   cla_word_t sum;
   logic      cout;
   logic      grp_p;
   logic      grp_g;
   cla_word_t sum_q;
   logic      cout_q;

   modport master (
      output a, b, cin,
      input  sum, cout, grp_p, grp_g, sum_q, cout_q
   );

   modport slave (
      input  a, b, cin,
      output sum, cout, grp_p, grp_g, sum_q, cout_q
   );

endinterface : cla_four_bit_if

// File: rtl/cla_lookahead_unit.sv
// Two-level lookahead network for a four-bit slice.
// Each carry is a flat sum of products of p/g/cin, so no carry waits on a
// lower computed carry. The group terms are exported so that a wider
// hierarchical CLA can stack this slice.
module cla_lookahead_unit
   import cla_pkg::*;
(
   input  cla_word_t  p_i,
   input  cla_word_t  g_i,
   input  logic       cin_i,
   output logic [3:1] c_o,
   output logic       cout_o,
   output logic       grp_p_o,
   output logic       grp_g_o
);

   // The group terms are independent of cin, so the next level can use them
   // before this slice's carry in settles.
   always_comb begin
      grp_p_o = p_i[3] & p_i[2] & p_i[1] & p_i[0];
      grp_g_o = g_i[3]
              | (p_i[3] & g_i[2])
              | (p_i[3] & p_i[2] & g_i[1])
              | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
   end

   // The internal carries and the carry out are all expanded directly from cin.
   always_comb begin
      c_o[1] = g_i[0]
             | (p_i[0] & cin_i);
      c_o[2] = g_i[1]
             | (p_i[1] & g_i[0])
             | (p_i[1] & p_i[0] & cin_i);
      c_o[3] = g_i[2]
             | (p_i[2] & g_i[1])
             | (p_i[2] & p_i[1] & g_i[0])
             | (p_i[2] & p_i[1] & p_i[0] & cin_i);
      cout_o = grp_g_o | (grp_p_o & cin_i);
   end

endmodule : cla_lookahead_unit

// File: rtl/cla_four_bit.sv
// Four-bit carry-lookahead adder slice.
// The outputs sum, cout and the group terms are combinational.
// The outputs sum_q and cout_q are copies of sum and cout, delayed by one cycle.
module cla_four_bit
   import cla_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   cla_four_bit_if.slave  bus
);

   cla_word_t  p;
   cla_word_t  g;
   logic [3:1] c_hi;
   cla_word_t  carry;
   cla_word_t  sum_d;
   logic       cout_d;
   logic       grp_p;
   logic       grp_g;
   cla_word_t  sum_q;
   logic       cout_q;

   // Per-bit generate and XOR propagate. The propagate term is reused for the sum.
   always_comb begin
      g = bus.a & bus.b;
      p = bus.a ^ bus.b;
   end

   cla_lookahead_unit u_lookahead (
      .p_i     (p),
      .g_i     (g),
      .cin_i   (bus.cin),
      .c_o     (c_hi),
      .cout_o  (cout_d),
      .grp_p_o (grp_p),
      .grp_g_o (grp_g)
   );

   // Sum bits: the propagate term XOR the lookahead carry into each bit.
   always_comb begin
      carry = {c_hi, bus.cin};
      sum_d = p ^ carry;
   end

   // Pipeline copy of the result. Reset clears only these flops.
   // NOTE: sequential state uses non-blocking assignments so that every flop
   // samples pre-edge values, whatever order the always blocks run in.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign bus.sum    = sum_d;
   assign bus.cout   = cout_d;
   assign bus.grp_p  = grp_p;
   assign bus.grp_g  = grp_g;
   assign bus.sum_q  = sum_q;
   assign bus.cout_q = cout_q;

endmodule : cla_four_bit

// File: tb/tb_cla_four_bit.sv
// Directed and exhaustive bench for cla_four_bit.
// The combinational checks run before the clock starts. The registered checks follow.
module tb_cla_four_bit;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [4:0] exp_res;   // {cout, sum}
      logic       chk_grp;
      logic       exp_p;
      logic       exp_g;
   } vec_t;

   logic clk;
   logic rst;
   logic clk_en;
   int   pass_cnt;
   int   total_cnt;

   cla_four_bit_if bus ();

   cla_four_bit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin);
      bus.a   = a;
      bus.b   = b;
      bus.cin = cin;
      #1;
   endtask

   vec_t vecs [9];

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      clk_en    = 1'b0;
      rst       = 1'b0;

      vecs[0] = '{4'b1011, 4'b0110, 1'b1, 5'b1_0010, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{4'b0010, 4'b1101, 1'b0, 5'b0_1111, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{4'b1111, 4'b0001, 1'b1, 5'b1_0001, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{4'b1111, 4'b1111, 1'b1, 5'b1_1111, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{4'b0000, 4'b0000, 1'b0, 5'b0_0000, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{4'b1111, 4'b0000, 1'b1, 5'b1_0000, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{4'b0101, 4'b1010, 1'b0, 5'b0_1111, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{4'b0101, 4'b1010, 1'b1, 5'b1_0000, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{4'b1000, 4'b1000, 1'b0, 5'b1_0000, 1'b1, 1'b0, 1'b1};

      // Directed vectors with no clock running.
      for (int i = 0; i < 9; i++) begin
         apply(vecs[i].a, vecs[i].b, vecs[i].cin);
         check($sformatf("vec%0d_res", i), 8'({bus.cout, bus.sum}), 8'(vecs[i].exp_res));
         if (vecs[i].chk_grp) begin
            check($sformatf("vec%0d_grp_p", i), 8'(bus.grp_p), 8'(vecs[i].exp_p));
            check($sformatf("vec%0d_grp_g", i), 8'(bus.grp_g), 8'(vecs[i].exp_g));
         end
      end

      // Exhaustive sweep. Group propagate holds exactly when a+b is 15.
      // Group generate holds exactly when a+b is 16 or more.
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               apply(4'(ai), 4'(bi), 1'(ci));
               check("sweep_res", 8'({bus.cout, bus.sum}), 8'(ai + bi + ci));
               check("sweep_cout_rel", 8'(bus.cout), 8'(bus.grp_g | (bus.grp_p & bus.cin)));
               check("sweep_grp_p", 8'(bus.grp_p), 8'((ai + bi) == 15));
               check("sweep_grp_g", 8'(bus.grp_g), 8'((ai + bi) >= 16));
            end
         end
      end

      // Registered path. Inputs change on the falling edge, and samples are taken 1 time unit after the rising edge.
      rst = 1'b1;
      apply(4'b1011, 4'b0110, 1'b1);
      clk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sum_q", 8'(bus.sum_q), 8'h00);
      check("rst_cout_q", 8'(bus.cout_q), 8'h00);
      check("rst_comb_res", 8'({bus.cout, bus.sum}), 8'h12);

      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rel_sum_q", 8'(bus.sum_q), 8'h02);
      check("rel_cout_q", 8'(bus.cout_q), 8'h01);

      @(negedge clk);
      apply(4'b0010, 4'b1101, 1'b0);
      check("pre_edge_sum_q", 8'(bus.sum_q), 8'h02);
      @(posedge clk);
      #1;
      check("pipe_sum_q", 8'(bus.sum_q), 8'h0f);
      check("pipe_cout_q", 8'(bus.cout_q), 8'h00);

      @(negedge clk);
      apply(4'b1111, 4'b1111, 1'b1);
      rst = 1'b1;
      check("mid_rst_hold_sum_q", 8'(bus.sum_q), 8'h0f);
      @(posedge clk);
      #1;
      check("mid_rst_sum_q", 8'(bus.sum_q), 8'h00);
      check("mid_rst_cout_q", 8'(bus.cout_q), 8'h00);
      check("mid_rst_comb_res", 8'({bus.cout, bus.sum}), 8'h1f);

      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rel2_sum_q", 8'(bus.sum_q), 8'h0f);
      check("rel2_cout_q", 8'(bus.cout_q), 8'h01);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_cla_four_bit
